mdu_multicycle: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the EX stage of the pipelined MIPS core. Successor to the fixed 32-bit MDU.
- Adds configurable operand width and per-class latencies, multiply-accumulate modes (MADD/MADDU/MSUB/MSUBU), a completion pulse, and defined divide-by-zero and overflow behaviour.
- Start is suppressed by the interrupt/exception request.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_arith.sv | 66 ++++++
 rtl/mdu_multicycle.sv | 111 +++++++++++
 tb/tb_mdu_multicycle.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op encoding, FSM states and op-class helpers for the multi-cycle MDU
package mdu_pkg;

    localparam logic [3:0] NOP   = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MADD  = 4'd5;
    localparam logic [3:0] MADDU = 4'd6;
    localparam logic [3:0] MSUB  = 4'd7;
    localparam logic [3:0] MSUBU = 4'd8;
    localparam logic [3:0] MTHI  = 4'd9;
    localparam logic [3:0] MTLO  = 4'd10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic is_mul_class(input logic [3:0] code);
        return code inside {MULT, MULTU, MADD, MADDU, MSUB, MSUBU};
    endfunction

    function automatic logic is_div_class(input logic [3:0] code);
        return code inside {DIV, DIVU};
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational multiply/accumulate/divide datapath producing the next HI/LO
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo,
    output logic             div0
);

    localparam int W2 = 2 * WIDTH;

    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [W2-1:0]    a_ext;
    logic [W2-1:0]    b_ext;
    logic [W2-1:0]    prod;
    logic [W2-1:0]    acc;
    logic [W2-1:0]    res;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;

    always_comb begin
        sgn   = op inside {MULT, DIV, MADD, MSUB};
        a_ext = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_ext = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod  = a_ext * b_ext;
        acc   = {hi, lo};

        // Divide on magnitudes so MIN / -1 lands on MIN without signed overflow.
        a_neg   = sgn & a[WIDTH-1];
        b_neg   = sgn & b[WIDTH-1];
        a_mag   = a_neg ? -a : a;
        b_mag   = b_neg ? -b : b;
        div0    = is_div_class(op) && (b == '0);
        divisor = (b == '0) ? WIDTH'(1) : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        q       = (a_neg ^ b_neg) ? -q_mag : q_mag;
        r       = a_neg ? -r_mag : r_mag;

        case (op)
            MULT, MULTU: res = prod;
            MADD, MADDU: res = acc + prod;
            MSUB, MSUBU: res = acc - prod;
            DIV, DIVU:   res = {r, q};
            default:     res = acc;
        endcase

        next_hi = res[W2-1:WIDTH];
        next_lo = res[WIDTH-1:0];
    end

endmodule

// File: rtl/mdu_multicycle.sv
// rtl/mdu_multicycle.sv - multi-cycle MDU top: issue FSM, latency counter and HI/LO registers
module mdu_multicycle
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cancel,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    logic             p_div0;
    logic [WIDTH-1:0] next_hi;
    logic [WIDTH-1:0] next_lo;
    logic             div0;
    logic             accept;
    logic             load;
    logic             commit;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op      (op),
        .a       (a),
        .b       (b),
        .hi      (hi),
        .lo      (lo),
        .next_hi (next_hi),
        .next_lo (next_lo),
        .div0    (div0)
    );

    assign accept = start && !cancel && (state == IDLE);
    assign busy   = (state == BUSY);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && (is_mul_class(op) || is_div_class(op))) begin
                    state_n = BUSY;
                    load    = 1'b1;
                    cnt_n   = is_div_class(op) ? DIV_CNT : MUL_CNT;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    commit  = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            p_div0 <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            done  <= commit;
            if (load) begin
                p_hi   <= next_hi;
                p_lo   <= next_lo;
                p_div0 <= div0;
            end
            // Divide by zero still takes the full window but leaves HI/LO alone.
            if (commit && !p_div0) begin
                hi <= p_hi;
                lo <= p_lo;
            end else if (accept && op == MTHI) begin
                hi <= a;
            end else if (accept && op == MTLO) begin
                lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_mdu_multicycle.sv
// tb/tb_mdu_multicycle.sv - randomized self-checking bench for mdu_multicycle against an arithmetic model
module tb_mdu_multicycle;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cancel;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_multicycle #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .cancel (cancel),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int op_lat(input logic [3:0] o);
        case (o)
            MULT, MULTU, MADD, MADDU, MSUB, MSUBU: return 5;
            DIV, DIVU:                             return 10;
            default:                               return 0;
        endcase
    endfunction

    task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] acc;
        longint      sx, sy, ux, uy, q, r;
        acc = {m_hi, m_lo};
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = longint'({32'd0, x});
        uy  = longint'({32'd0, y});
        case (o)
            MULT:  acc = sx * sy;
            MULTU: acc = ux * uy;
            MADD:  acc = acc + sx * sy;
            MADDU: acc = acc + ux * uy;
            MSUB:  acc = acc - sx * sy;
            MSUBU: acc = acc - ux * uy;
            DIV:   if (y != 0) begin q = sx / sy; r = sx % sy; acc = {r[31:0], q[31:0]}; end
            DIVU:  if (y != 0) begin q = ux / uy; r = ux % uy; acc = {r[31:0], q[31:0]}; end
            MTHI:  acc[63:32] = x;
            MTLO:  acc[31:0]  = x;
            default: ;
        endcase
        m_hi = acc[63:32];
        m_lo = acc[31:0];
    endtask

    // Called on a negedge with the unit idle; returns on the negedge where done should show.
    task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int lat;
        int n;
        lat = op_lat(o);
        expect_eq("issue_idle", busy, 0);
        start = 1'b1; op = o; a = x; b = y;
        model(o, x, y);
        @(negedge clk);
        start = 1'b0; op = NOP;
        n = 0;
        while (busy && n < 200) begin
            expect_eq("done_in_busy", done, 0);
            n++;
            cancel = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        cancel = 1'b0;
        expect_eq("busy_len", n, lat);
        expect_eq("done", done, (lat != 0) ? 1 : 0);
        expect_eq("hi", hi, m_hi);
        expect_eq("lo", lo, m_lo);
    endtask

    initial begin
        logic [3:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b0; cancel = 1'b0; start = 1'b0; op = NOP; a = '0; b = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        expect_eq("rst_hi", hi, 0);
        expect_eq("rst_lo", lo, 0);
        expect_eq("rst_busy", busy, 0);
        expect_eq("rst_done", done, 0);

        do_op(MULT, 32'hFFFFFFFD, 32'd5);
        expect_eq("mult_hi", hi, 32'hFFFFFFFF);
        expect_eq("mult_lo", lo, 32'hFFFFFFF1);

        do_op(DIV, 32'hFFFFFFF9, 32'd2);
        expect_eq("div_lo", lo, 32'hFFFFFFFD);
        expect_eq("div_hi", hi, 32'hFFFFFFFF);
        do_op(DIVU, 32'hFFFFFFF9, 32'd2);
        expect_eq("divu_lo", lo, 32'h7FFFFFFC);
        expect_eq("divu_hi", hi, 32'd1);

        do_op(MTHI, 32'd1, 32'd0);
        do_op(MTLO, 32'd2, 32'd0);
        do_op(MADDU, 32'hFFFFFFFF, 32'd2);
        do_op(MSUB, 32'd1, 32'd1);

        do_op(MTHI, 32'hAA, 32'd0);
        do_op(MTLO, 32'hBB, 32'd0);
        do_op(DIV, 32'd1234, 32'd0);
        expect_eq("div0_hi", hi, 32'hAA);
        expect_eq("div0_lo", lo, 32'hBB);
        do_op(DIV, 32'h80000000, 32'hFFFFFFFF);
        expect_eq("min_lo", lo, 32'h80000000);
        expect_eq("min_hi", hi, 32'd0);

        // Start suppressed by a simultaneous cancel.
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = MULT; a = 32'd2; b = 32'd3;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0; op = NOP;
        expect_eq("cancel_busy", busy, 0);
        expect_eq("cancel_done", done, 0);
        expect_eq("cancel_hi", hi, m_hi);
        expect_eq("cancel_lo", lo, m_lo);

        // Reset on the third busy cycle discards the op.
        start = 1'b1; op = MULT; a = 32'd7; b = 32'd9;
        @(negedge clk);
        start = 1'b0; op = NOP;
        expect_eq("pre_rst_busy", busy, 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        expect_eq("mid_rst_busy", busy, 0);
        expect_eq("mid_rst_hi", hi, 0);
        expect_eq("mid_rst_lo", lo, 0);
        expect_eq("mid_rst_done", done, 0);
        @(negedge clk);
        expect_eq("mid_rst_nodone", done, 0);

        // Back-to-back: second MULT issued on the done cycle of the first.
        do_op(MULT, 32'd6, 32'd7);
        do_op(MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);

        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 10));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 16));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'h80000000;
            do_op(ro, ra, rb);
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
